// File: rtl/bypass_rf_wr_arb_if.sv
// rtl/bypass_rf_wr_arb_if.sv - requester and register-file write-port bundle for bypass_rf_wr_arb
interface bypass_rf_wr_arb_if #(
  parameter int name_width = 1,
  parameter int data_width = 1,
  parameter int cnt_width  = 16
);
  logic [3:0]              REQ_V;
  logic [4*name_width-1:0] REQ_NAME;
  logic [4*data_width-1:0] REQ_DATA;
  logic [3:0]              REQ_RDY;
  logic [name_width-1:0]   NAME_IN_1;
  logic [data_width-1:0]   D_IN_1;
  logic                    WE_1;
  logic [name_width-1:0]   NAME_IN_2;
  logic [data_width-1:0]   D_IN_2;
  logic                    WE_2;
  logic [cnt_width-1:0]    CONFLICT_CNT;

  modport master (
    output REQ_V, REQ_NAME, REQ_DATA,
    input  REQ_RDY, NAME_IN_1, D_IN_1, WE_1, NAME_IN_2, D_IN_2, WE_2, CONFLICT_CNT
  );

  modport slave (
    input  REQ_V, REQ_NAME, REQ_DATA,
    output REQ_RDY, NAME_IN_1, D_IN_1, WE_1, NAME_IN_2, D_IN_2, WE_2, CONFLICT_CNT
  );
endinterface

// File: rtl/bypass_rf_wr_arb.sv
// rtl/bypass_rf_wr_arb.sv - four one-entry writeback buffers arbitrated round-robin onto two register-file write ports
// Define BYPASS_RF_WR_ARB_STATS_EN to build the saturating conflict-cycle counter (CONFLICT_CNT).
module bypass_rf_wr_arb #(
  parameter int name_width = 1,
  parameter int data_width = 1,
  parameter int cnt_width  = 16
) (
  input logic               CLK,
  input logic               RST,
  bypass_rf_wr_arb_if.slave bus
);

  logic [3:0]            full;
  logic [3:0]            full_nxt;
  logic [name_width-1:0] name_q [4];
  logic [data_width-1:0] data_q [4];
  logic [1:0]            ptr;
  logic [1:0]            ptr_nxt;

  logic                  gnt1_v;
  logic                  gnt2_v;
  logic [1:0]            gnt1_idx;
  logic [1:0]            gnt2_idx;
  logic [1:0]            scan_idx;
  logic [3:0]            gnt;
  logic [3:0]            rdy;
  logic [3:0]            accept;

  // Grants depend only on stored state, so REQ_RDY never sees REQ_V combinationally.
  always_comb begin
    gnt1_v   = 1'b0;
    gnt2_v   = 1'b0;
    gnt1_idx = 2'd0;
    gnt2_idx = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (full[scan_idx]) begin
        if (!gnt1_v) begin
          gnt1_v   = 1'b1;
          gnt1_idx = scan_idx;
        end else if (!gnt2_v && (name_q[scan_idx] != name_q[gnt1_idx])) begin
          gnt2_v   = 1'b1;
          gnt2_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    gnt = 4'b0000;
    if (gnt1_v) gnt[gnt1_idx] = 1'b1;
    if (gnt2_v) gnt[gnt2_idx] = 1'b1;
  end

  // Port 2 is always later in scan order than port 1, so it is the last grant when present.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt2_v) begin
      ptr_nxt = gnt2_idx + 2'd1;
    end else if (gnt1_v) begin
      ptr_nxt = gnt1_idx + 2'd1;
    end
  end

  assign rdy      = ~full | gnt;
  assign accept   = bus.REQ_V & rdy;
  assign full_nxt = accept | (full & ~gnt);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full <= 4'b0000;
      ptr  <= 2'd0;
    end else begin
      full <= full_nxt;
      ptr  <= ptr_nxt;
    end
  end

  // Payload registers carry no reset; they are only observed while their full flag is set.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        name_q[i] <= bus.REQ_NAME[i*name_width +: name_width];
        data_q[i] <= bus.REQ_DATA[i*data_width +: data_width];
      end
    end
  end

  assign bus.REQ_RDY   = rdy;
  assign bus.WE_1      = gnt1_v;
  assign bus.NAME_IN_1 = gnt1_v ? name_q[gnt1_idx] : '0;
  assign bus.D_IN_1    = gnt1_v ? data_q[gnt1_idx] : '0;
  assign bus.WE_2      = gnt2_v;
  assign bus.NAME_IN_2 = gnt2_v ? name_q[gnt2_idx] : '0;
  assign bus.D_IN_2    = gnt2_v ? data_q[gnt2_idx] : '0;

`ifdef BYPASS_RF_WR_ARB_STATS_EN
  logic [cnt_width-1:0] cnt_q;
  logic [2:0]           n_full;

  assign n_full = {2'b00, full[0]} + {2'b00, full[1]} + {2'b00, full[2]} + {2'b00, full[3]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if ((n_full >= 3'd3) && (cnt_q != {cnt_width{1'b1}})) begin
      cnt_q <= cnt_q + cnt_width'(1);
    end
  end

  assign bus.CONFLICT_CNT = cnt_q;
`else
  assign bus.CONFLICT_CNT = '0;
`endif

endmodule
